decode_session_controller: RTL and testbench

Host-side sequencer between a syndrome producer and the `Helios_single_FPGA` byte-stream port. It issues the one-time start-decoding message after reset. For each frame it sends the measurement-data header and then serialises the frame's rounds into bytes. It then collects the fixed-length result message and presents it as a single parsed record, with a frame ID and a timeout indication.

---
 rtl/decode_session_controller_pkg.sv | 23 ++
 rtl/decode_session_controller_result_parser.sv | 76 +++++++
 rtl/decode_session_controller.sv | 170 +++++++++++++++++
 tb/tb_decode_session_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_session_controller_pkg.sv
// Shared constants, state encoding and sizing helper for the decode session controller.
package decode_session_controller_pkg;

   localparam logic [7:0]  START_DECODING_MSG      = 8'h01;
   localparam logic [7:0]  MEASUREMENT_DATA_HEADER = 8'h02;
   localparam int unsigned RESULT_MIN_BYTES        = 3;

   typedef enum logic [2:0] {
      ST_START,
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_WAIT,
      ST_COLLECT,
      ST_EMIT
   } state_e;

   // Counter width able to index 0..n-1, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/decode_session_controller_result_parser.sv
// Counts result bytes, captures the record fields and watches for an idle timeout.
module decode_session_controller_result_parser
   import decode_session_controller_pkg::*;
#(
   parameter int unsigned RESULT_BYTES   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        active,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        done,
   output logic        timeout,
   output logic [7:0]  iterations,
   output logic [15:0] cycles
);

   localparam int unsigned RX_W = idx_width(RESULT_BYTES);
   localparam int unsigned TO_W = idx_width(TIMEOUT_CYCLES);

   if (RESULT_BYTES < RESULT_MIN_BYTES) begin : g_bad_result_bytes
      $error("RESULT_BYTES must be at least %0d", RESULT_MIN_BYTES);
   end

   logic [RX_W-1:0] rx_idx_q, rx_idx_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]      iter_q, iter_d;
   logic [15:0]     cyc_q, cyc_d;
   logic            accept;

   // Byte acceptance, capture of fields 0..2 and timeout counting.
   always_comb begin
      rx_idx_d = rx_idx_q;
      to_cnt_d = to_cnt_q;
      iter_d   = iter_q;
      cyc_d    = cyc_q;
      accept   = active && byte_valid;
      done     = accept && (rx_idx_q == RX_W'(RESULT_BYTES - 1));
      timeout  = active && !accept && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
      if (clear) begin
         rx_idx_d = '0;
         to_cnt_d = '0;
         iter_d   = 8'h00;
         cyc_d    = 16'h0000;
      end else if (accept) begin
         to_cnt_d = '0;
         rx_idx_d = rx_idx_q + RX_W'(1);
         if (rx_idx_q == RX_W'(0)) iter_d       = byte_data;
         if (rx_idx_q == RX_W'(1)) cyc_d[15:8]  = byte_data;
         if (rx_idx_q == RX_W'(2)) cyc_d[7:0]   = byte_data;
      end else if (active) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   // Parser state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_idx_q <= '0;
         to_cnt_q <= '0;
         iter_q   <= 8'h00;
         cyc_q    <= 16'h0000;
      end else begin
         rx_idx_q <= rx_idx_d;
         to_cnt_q <= to_cnt_d;
         iter_q   <= iter_d;
         cyc_q    <= cyc_d;
      end
   end

   assign iterations = iter_q;
   assign cycles     = cyc_q;

endmodule

// File: rtl/decode_session_controller.sv
// Sequences start message, frame header and round bytes to the decoder, then parses its result.
module decode_session_controller
   import decode_session_controller_pkg::*;
#(
   parameter int unsigned BYTES_PER_ROUND = 1,
   parameter int unsigned ROUNDS          = 5,
   parameter int unsigned RESULT_BYTES    = 3,
   parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [8*BYTES_PER_ROUND-1:0] round_data,
   input  logic                         round_valid,
   output logic                         round_ready,
   output logic [7:0]                   dec_in_data,
   output logic                         dec_in_valid,
   input  logic                         dec_in_ready,
   input  logic [7:0]                   dec_out_data,
   input  logic                         dec_out_valid,
   output logic                         dec_out_ready,
   output logic [7:0]                   res_iterations,
   output logic [15:0]                  res_cycles,
   output logic [15:0]                  res_frame_id,
   output logic                         res_timeout,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic                         busy,
   output logic                         error
);

   localparam int unsigned BI_W = idx_width(BYTES_PER_ROUND);
   localparam int unsigned RI_W = idx_width(ROUNDS);

   state_e          state_q, state_d;
   logic [BI_W-1:0] byte_idx_q, byte_idx_d;
   logic [RI_W-1:0] round_idx_q, round_idx_d;
   logic [15:0]     frame_id_q, frame_id_d;
   logic            res_timeout_q, res_timeout_d;
   logic            error_q, error_d;
   logic            last_byte, last_round, data_hs;
   logic            parser_clear, parser_done, parser_timeout;
   logic [7:0]      round_byte;

   // Selects the round byte addressed by byte_idx.
   always_comb begin
      round_byte = round_data[7:0];
      for (int unsigned b = 0; b < BYTES_PER_ROUND; b++) begin
         if (byte_idx_q == BI_W'(b)) round_byte = round_data[8*b +: 8];
      end
   end

   // Port-side decode of the current state.
   always_comb begin
      last_byte     = (byte_idx_q == BI_W'(BYTES_PER_ROUND - 1));
      last_round    = (round_idx_q == RI_W'(ROUNDS - 1));
      data_hs       = (state_q == ST_DATA) && round_valid && dec_in_ready;
      dec_in_valid  = 1'b0;
      dec_in_data   = 8'h00;
      case (state_q)
         ST_START: begin
            dec_in_valid = 1'b1;
            dec_in_data  = START_DECODING_MSG;
         end
         ST_HEADER: begin
            dec_in_valid = 1'b1;
            dec_in_data  = MEASUREMENT_DATA_HEADER;
         end
         ST_DATA: begin
            dec_in_valid = round_valid;
            dec_in_data  = round_byte;
         end
         default: ;
      endcase
      round_ready   = data_hs && last_byte;
      parser_clear  = data_hs && last_byte && last_round;
      dec_out_ready = (state_q == ST_WAIT) || (state_q == ST_COLLECT);
      res_valid     = (state_q == ST_EMIT);
      busy          = (state_q != ST_IDLE);
   end

   // Next-state, index, frame-id and flag computation.
   always_comb begin
      state_d       = state_q;
      byte_idx_d    = byte_idx_q;
      round_idx_d   = round_idx_q;
      frame_id_d    = frame_id_q;
      res_timeout_d = res_timeout_q;
      error_d       = error_q;
      case (state_q)
         ST_START:  if (dec_in_ready) state_d = ST_IDLE;
         ST_IDLE:   if (round_valid) state_d = ST_HEADER;
         ST_HEADER: if (dec_in_ready) state_d = ST_DATA;
         ST_DATA: begin
            if (data_hs) begin
               if (last_byte) begin
                  byte_idx_d = '0;
                  if (last_round) begin
                     round_idx_d = '0;
                     state_d     = ST_WAIT;
                  end else begin
                     round_idx_d = round_idx_q + RI_W'(1);
                  end
               end else begin
                  byte_idx_d = byte_idx_q + BI_W'(1);
               end
            end
         end
         ST_WAIT, ST_COLLECT: begin
            if (parser_timeout) begin
               state_d       = ST_EMIT;
               res_timeout_d = 1'b1;
               error_d       = 1'b1;
            end else if (parser_done) begin
               state_d       = ST_EMIT;
               res_timeout_d = 1'b0;
            end else if ((state_q == ST_WAIT) && dec_out_valid) begin
               state_d = ST_COLLECT;
            end
         end
         ST_EMIT: begin
            if (res_ready) begin
               state_d       = ST_IDLE;
               frame_id_d    = frame_id_q + 16'd1;
               res_timeout_d = 1'b0;
            end
         end
         default: state_d = ST_START;
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_START;
         byte_idx_q    <= '0;
         round_idx_q   <= '0;
         frame_id_q    <= 16'h0000;
         res_timeout_q <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_idx_q    <= byte_idx_d;
         round_idx_q   <= round_idx_d;
         frame_id_q    <= frame_id_d;
         res_timeout_q <= res_timeout_d;
         error_q       <= error_d;
      end
   end

   decode_session_controller_result_parser #(
      .RESULT_BYTES   (RESULT_BYTES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_result_parser (
      .clk        (clk),
      .reset      (reset),
      .clear      (parser_clear),
      .active     (dec_out_ready),
      .byte_data  (dec_out_data),
      .byte_valid (dec_out_valid),
      .done       (parser_done),
      .timeout    (parser_timeout),
      .iterations (res_iterations),
      .cycles     (res_cycles)
   );

   assign res_frame_id = frame_id_q;
   assign res_timeout  = res_timeout_q;
   assign error        = error_q;

endmodule

// File: tb/tb_decode_session_controller.sv
// Randomized scoreboard bench for decode_session_controller.
module tb_decode_session_controller;
   import decode_session_controller_pkg::*;

   localparam int unsigned BPR = 2;
   localparam int unsigned ROUNDS = 3;
   localparam int unsigned RB = 4;
   localparam int unsigned TO = 16;
   localparam int BUDGET = 2000;

   typedef struct {
      logic [7:0]  it;
      logic [15:0] cy;
      logic [15:0] fid;
      logic        to;
      int          kind;   // 0 full result, 1 no bytes, 2 two bytes then silence
   } rec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [8*BPR-1:0] round_data;
   logic             round_valid, round_ready;
   logic [7:0]       dec_in_data;
   logic             dec_in_valid, dec_in_ready;
   logic [7:0]       dec_out_data;
   logic             dec_out_valid, dec_out_ready;
   logic [7:0]       res_iterations;
   logic [15:0]      res_cycles, res_frame_id;
   logic             res_timeout, res_valid, res_ready;
   logic             busy, error;

   decode_session_controller #(
      .BYTES_PER_ROUND (BPR),
      .ROUNDS          (ROUNDS),
      .RESULT_BYTES    (RB),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .round_data     (round_data),
      .round_valid    (round_valid),
      .round_ready    (round_ready),
      .dec_in_data    (dec_in_data),
      .dec_in_valid   (dec_in_valid),
      .dec_in_ready   (dec_in_ready),
      .dec_out_data   (dec_out_data),
      .dec_out_valid  (dec_out_valid),
      .dec_out_ready  (dec_out_ready),
      .res_iterations (res_iterations),
      .res_cycles     (res_cycles),
      .res_frame_id   (res_frame_id),
      .res_timeout    (res_timeout),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .busy           (busy),
      .error          (error)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_in_q[$];
   rec_t       exp_rec_q[$];
   int  cyc = 0, last_in_cyc = 0, last_out_cyc = 0;
   int  rr_count = 0, rr_model = 0, rec_done = 0;
   int  fid_model = 0;
   bit  err_model = 1'b0;
   bit  stall_en = 1'b0;
   int  res_wait = 0;
   logic prev_v = 1'b0, prev_r = 1'b0;
   logic [40:0] held;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void fail_event(string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: event did not occur / unexpected event (t=%0t)", name, $time);
   endfunction

   // Monitor: compares every DUT handshake against the scoreboard queues.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         prev_v = 1'b0;
         prev_r = 1'b0;
      end else begin
         if (dec_in_valid && dec_in_ready) begin
            if (exp_in_q.size() == 0) fail_event("dec_in_unexpected_byte");
            else check("dec_in_byte", 64'(dec_in_data), 64'(exp_in_q.pop_front()));
            last_in_cyc = cyc;
         end
         if (round_ready) begin
            rr_count++;
            check("round_ready_on_top_byte", 64'({dec_in_valid, dec_in_ready, dec_in_data}),
                  64'({2'b11, round_data[15:8]}));
         end
         if (dec_out_valid && dec_out_ready) last_out_cyc = cyc;
         if (prev_v && !prev_r) begin
            check("res_valid_hold", 64'(res_valid), 64'(1));
            check("res_fields_hold", 64'({res_iterations, res_cycles, res_frame_id, res_timeout}), 64'(held));
         end else if (res_valid) begin
            if (exp_rec_q.size() == 0) fail_event("res_unexpected_record");
            else begin
               rec_t e;
               e = exp_rec_q.pop_front();
               check("res_iterations", 64'(res_iterations), 64'(e.it));
               check("res_cycles", 64'(res_cycles), 64'(e.cy));
               check("res_frame_id", 64'(res_frame_id), 64'(e.fid));
               check("res_timeout", 64'(res_timeout), 64'(e.to));
               err_model = err_model | e.to;
               check("error_sticky", 64'(error), 64'(err_model));
               if (e.kind == 0) check("res_latency", 64'(cyc - last_out_cyc), 64'(1));
               else if (e.kind == 1) check("timeout_latency_nobytes", 64'(cyc - last_in_cyc), 64'(TO + 1));
               else check("timeout_latency_partial", 64'(cyc - last_out_cyc), 64'(TO + 1));
            end
         end
         if (res_valid && res_ready) rec_done++;
         prev_v = res_valid;
         prev_r = res_ready;
         held   = {res_iterations, res_cycles, res_frame_id, res_timeout};
      end
   end

   // Ready drivers: random decoder-input backpressure, record consumer waits res_wait cycles.
   initial begin
      int vcnt;
      vcnt = 0;
      dec_in_ready = 1'b1;
      res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         dec_in_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (!res_valid) vcnt = 0;
         else vcnt++;
         res_ready = (vcnt > res_wait);
      end
   end

   task automatic check_reset_values();
      check("rst_dec_in_valid", 64'(dec_in_valid), 64'(1));
      check("rst_dec_in_data", 64'(dec_in_data), 64'(START_DECODING_MSG));
      check("rst_ready_outs", 64'({round_ready, dec_out_ready}), 64'(0));
      check("rst_res_flags", 64'({res_valid, res_timeout, error}), 64'(0));
      check("rst_busy", 64'(busy), 64'(1));
      check("rst_res_data", 64'({res_iterations, res_cycles, res_frame_id}), 64'(0));
   endtask

   task automatic send_round(input logic [15:0] r);
      int b;
      round_data  = r;
      round_valid = 1'b1;
      b = 0;
      do begin
         @(negedge clk);
         b++;
      end while (!round_ready && b < BUDGET);
      if (b >= BUDGET) fail_event("round_handshake_wait");
      @(posedge clk);
      #1;
      round_valid = 1'b0;
      round_data  = 16'($urandom);
   endtask

   task automatic send_result_byte(input logic [7:0] v);
      int b;
      dec_out_data  = v;
      dec_out_valid = 1'b1;
      b = 0;
      do begin
         @(negedge clk);
         b++;
      end while (!dec_out_ready && b < BUDGET);
      if (b >= BUDGET) fail_event("result_handshake_wait");
      @(posedge clk);
      #1;
      dec_out_valid = 1'b0;
      dec_out_data  = 8'($urandom);
   endtask

   task automatic run_frame(input int kind);
      logic [15:0] r [ROUNDS];
      logic [7:0]  rb [RB];
      rec_t        e;
      int          nsend, start_done, b;
      exp_in_q.push_back(MEASUREMENT_DATA_HEADER);
      for (int i = 0; i < ROUNDS; i++) begin
         r[i] = 16'($urandom);
         exp_in_q.push_back(r[i][7:0]);
         exp_in_q.push_back(r[i][15:8]);
      end
      for (int k = 0; k < RB; k++) rb[k] = 8'($urandom);
      e.kind = kind;
      e.fid  = 16'(fid_model);
      e.to   = (kind != 0);
      e.it   = (kind == 1) ? 8'h00 : rb[0];
      e.cy   = (kind == 0) ? {rb[1], rb[2]} : (kind == 2) ? {rb[1], 8'h00} : 16'h0000;
      exp_rec_q.push_back(e);
      fid_model = (fid_model + 1) % 65536;
      rr_model += ROUNDS;
      nsend = (kind == 0) ? RB : (kind == 2) ? 2 : 0;
      start_done = rec_done;
      fork
         begin
            for (int i = 0; i < ROUNDS; i++) begin
               send_round(r[i]);
               if (stall_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
         end
         begin
            for (int k = 0; k < nsend; k++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               send_result_byte(rb[k]);
            end
         end
      join
      b = 0;
      while (rec_done == start_done && b < BUDGET) begin
         @(posedge clk);
         #1;
         b++;
      end
      if (b >= BUDGET) fail_event("record_wait");
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int kinds[6] = '{0, 0, 1, 0, 2, 0};
      reset         = 1'b1;
      round_valid   = 1'b0;
      round_data    = '0;
      dec_out_valid = 1'b0;
      dec_out_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      exp_in_q.push_back(START_DECODING_MSG);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("busy_during_start", 64'(busy), 64'(1));
      @(negedge clk);
      check("start_sent_once", 64'(exp_in_q.size()), 64'(0));
      check("idle_after_start", 64'({busy, dec_in_valid}), 64'(0));
      @(posedge clk);
      #1;

      for (int f = 0; f < 6; f++) begin
         res_wait = (f == 0) ? 4 : int'($urandom_range(0, 3));
         if (f == 2) stall_en = 1'b1;
         run_frame(kinds[f]);
      end
      for (int f = 0; f < 8; f++) begin
         res_wait = int'($urandom_range(0, 4));
         run_frame(int'($urandom_range(0, 2)));
      end

      // Reset while in the data phase after two rounds.
      stall_en = 1'b0;
      begin
         logic [15:0] r0, r1;
         r0 = 16'($urandom);
         r1 = 16'($urandom);
         exp_in_q.push_back(MEASUREMENT_DATA_HEADER);
         exp_in_q.push_back(r0[7:0]);
         exp_in_q.push_back(r0[15:8]);
         exp_in_q.push_back(r1[7:0]);
         exp_in_q.push_back(r1[15:8]);
         rr_model += 2;
         send_round(r0);
         send_round(r1);
      end
      check("partial_frame_bytes_sent", 64'(exp_in_q.size()), 64'(0));
      reset = 1'b1;
      exp_in_q.delete();
      exp_rec_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      exp_in_q.push_back(START_DECODING_MSG);
      fid_model = 0;
      err_model = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      res_wait = 1;
      run_frame(0);

      repeat (3) @(posedge clk);
      check("round_ready_count", 64'(rr_count), 64'(rr_model));
      check("dec_in_queue_drained", 64'(exp_in_q.size()), 64'(0));
      check("record_queue_drained", 64'(exp_rec_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
